// File: rtl/ram_ctrl.sv
// ram_ctrl: request/response front-end for a single-port synchronous RAM.
// After reset it zero-fills every RAM word (when INIT_EN=1). Then it turns
// valid/ready requests into registered RAM strobes. Read data comes back
// through a one-entry response register.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_addr,
//   req_wdata                request: 1 = write / 0 = read, address, write data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                read data (0 for out-of-range reads)
//   init_done                zero-fill finished (sticky until rst)
//   ram_address, ram_in_data,
//   ram_rr, ram_ce           registered RAM strobes (ram_rr: 1 = write)
//   ram_out_data             RAM read data, one cycle after a read strobe
module ram_ctrl #(
    parameter int unsigned mem_width  = 16,
    parameter int unsigned mem_length = 8,
    parameter int unsigned add_length = 3,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [add_length-1:0] req_addr,
    input  logic [mem_width-1:0]  req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [mem_width-1:0]  rsp_rdata,
    output logic                  init_done,
    output logic [add_length-1:0] ram_address,
    output logic [mem_width-1:0]  ram_in_data,
    output logic                  ram_rr,
    output logic                  ram_ce,
    input  logic [mem_width-1:0]  ram_out_data
);

    typedef enum logic [2:0] {INIT, IDLE, WR, RD1, RD2} state_t;

    localparam state_t                RST_STATE = INIT_EN ? INIT : IDLE;
    localparam logic [add_length-1:0] LAST_ADDR = add_length'(mem_length - 1);

    state_t                state, state_nxt;
    logic [add_length-1:0] cnt, cnt_nxt;
    logic                  rsp_valid_nxt, init_done_nxt, ce_nxt, rr_nxt;
    logic [mem_width-1:0]  rsp_rdata_nxt, wdata_nxt;
    logic [add_length-1:0] addr_nxt;
    logic                  in_range;

    // Decoded from registers only; never depends on req_valid.
    assign req_ready = (state == IDLE) && !rsp_valid;
    assign in_range  = 32'(req_addr) < mem_length;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_STATE;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            init_done   <= !INIT_EN;
            ram_ce      <= 1'b0;
            ram_rr      <= 1'b0;
            ram_address <= '0;
            ram_in_data <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            init_done   <= init_done_nxt;
            ram_ce      <= ce_nxt;
            ram_rr      <= rr_nxt;
            ram_address <= addr_nxt;
            ram_in_data <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        init_done_nxt = init_done;
        ce_nxt        = ram_ce;
        rr_nxt        = ram_rr;
        addr_nxt      = ram_address;
        wdata_nxt     = ram_in_data;

        if (rsp_valid && rsp_ready) begin
            rsp_valid_nxt = 1'b0;
        end

        case (state)
            INIT: begin
                ce_nxt    = 1'b1;
                rr_nxt    = 1'b1;
                wdata_nxt = '0;
                addr_nxt  = cnt;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                ce_nxt        = 1'b0;
                rr_nxt        = 1'b0;
                init_done_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    state_nxt = req_we ? WR : RD1;
                    // Out-of-range requests still walk WR/RD1/RD2 for timing.
                    // They never raise the strobe, so RD2 can tell from
                    // ram_ce whether real data is coming back.
                    if (in_range) begin
                        ce_nxt   = 1'b1;
                        rr_nxt   = req_we;
                        addr_nxt = req_addr;
                        if (req_we) begin
                            wdata_nxt = req_wdata;
                        end
                    end
                end
            end
            WR: begin
                ce_nxt    = 1'b0;
                rr_nxt    = 1'b0;
                state_nxt = IDLE;
            end
            RD1: begin
                // Strobe held so ram_out_data stays stable into RD2.
                state_nxt = RD2;
            end
            RD2: begin
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = ram_ce ? ram_out_data : '0;
                ce_nxt        = 1'b0;
                rr_nxt        = 1'b0;
                state_nxt     = IDLE;
            end
            default: begin
                ce_nxt    = 1'b0;
                rr_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl. Instance 0 uses the defaults (INIT_EN=1,
// 8 words). Instance 1 uses INIT_EN=0 and 6 words. Each instance drives a
// small registered RAM model. That model is preset to a non-zero pattern so
// the zero-fill can be seen.
module tb_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        preset;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [2:0]  req_addr     [2];
    logic [15:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [15:0] rsp_rdata    [2];
    logic        init_done    [2];
    logic [2:0]  ram_address  [2];
    logic [15:0] ram_in_data  [2];
    logic        ram_rr       [2];
    logic        ram_ce       [2];
    logic [15:0] ram_out_data [2];
    logic [15:0] mem [2][8];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_ctrl #(.mem_width(16), .mem_length(8), .add_length(3), .INIT_EN(1'b1)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .init_done(init_done[0]),
        .ram_address(ram_address[0]), .ram_in_data(ram_in_data[0]),
        .ram_rr(ram_rr[0]), .ram_ce(ram_ce[0]), .ram_out_data(ram_out_data[0])
    );

    ram_ctrl #(.mem_width(16), .mem_length(6), .add_length(3), .INIT_EN(1'b0)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .init_done(init_done[1]),
        .ram_address(ram_address[1]), .ram_in_data(ram_in_data[1]),
        .ram_rr(ram_rr[1]), .ram_ce(ram_ce[1]), .ram_out_data(ram_out_data[1])
    );

    // Registered single-port RAM model: write on ce&rr, read data one cycle later.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (preset) begin
                for (int k = 0; k < 8; k++) mem[d][k] <= 16'hDEAD;
                ram_out_data[d] <= 16'hBAD0;
            end else if (ram_ce[d]) begin
                if (ram_rr[d]) mem[d][ram_address[d]] <= ram_in_data[d];
                else           ram_out_data[d] <= mem[d][ram_address[d]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq();
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("init_ce%0d", i),    ram_ce[0], 1);
            chk($sformatf("init_rr%0d", i),    ram_rr[0], 1);
            chk($sformatf("init_addr%0d", i),  ram_address[0], i);
            chk($sformatf("init_data%0d", i),  ram_in_data[0], 0);
            chk($sformatf("init_ready%0d", i), req_ready[0], (i == 7));
            chk($sformatf("init_done%0d", i),  init_done[0], 0);
            chk($sformatf("init_rsp%0d", i),   rsp_valid[0], 0);
        end
        step();
        chk("init_end_ce",   ram_ce[0], 0);
        chk("init_end_rr",   ram_rr[0], 0);
        chk("init_end_done", init_done[0], 1);
        chk("init_end_rdy",  req_ready[0], 1);
    endtask

    task automatic do_write(input int d, input logic [2:0] a, input logic [15:0] data,
                            input bit in_range);
        req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = a; req_wdata[d] = data;
        step();
        chk($sformatf("wr%0d_a%0d_ce", d, a), ram_ce[d], in_range);
        if (in_range) begin
            chk($sformatf("wr%0d_a%0d_rr", d, a),   ram_rr[d], 1);
            chk($sformatf("wr%0d_a%0d_addr", d, a), ram_address[d], a);
            chk($sformatf("wr%0d_a%0d_data", d, a), ram_in_data[d], data);
        end
        chk($sformatf("wr%0d_a%0d_busy", d, a), req_ready[d], 0);
        req_valid[d] = 1'b0;
        step();
        chk($sformatf("wr%0d_a%0d_ce_off", d, a), ram_ce[d], 0);
        chk($sformatf("wr%0d_a%0d_rr_off", d, a), ram_rr[d], 0);
        chk($sformatf("wr%0d_a%0d_rdy", d, a),    req_ready[d], 1);
        chk($sformatf("wr%0d_a%0d_norsp", d, a),  rsp_valid[d], 0);
    endtask

    task automatic do_read(input int d, input logic [2:0] a, input logic [15:0] exp,
                           input bit in_range);
        req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = a;
        step();
        chk($sformatf("rd%0d_a%0d_ce", d, a), ram_ce[d], in_range);
        chk($sformatf("rd%0d_a%0d_rr", d, a), ram_rr[d], 0);
        if (in_range) chk($sformatf("rd%0d_a%0d_addr", d, a), ram_address[d], a);
        req_valid[d] = 1'b0;
        step();
        chk($sformatf("rd%0d_a%0d_hold", d, a),  ram_ce[d], in_range);
        chk($sformatf("rd%0d_a%0d_early", d, a), rsp_valid[d], 0);
        step();
        chk($sformatf("rd%0d_a%0d_valid", d, a), rsp_valid[d], 1);
        chk($sformatf("rd%0d_a%0d_data", d, a),  rsp_rdata[d], exp);
        chk($sformatf("rd%0d_a%0d_ce_off", d, a), ram_ce[d], 0);
        chk($sformatf("rd%0d_a%0d_busy", d, a),  req_ready[d], 0);
        rsp_ready[d] = 1'b1;
        step();
        chk($sformatf("rd%0d_a%0d_clr", d, a), rsp_valid[d], 0);
        chk($sformatf("rd%0d_a%0d_rdy", d, a), req_ready[d], 1);
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        preset = 1'b1;
        rst    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   rsp_ready[d] = 1'b0;
        end
        step();
        preset = 1'b0;
        step();

        // Reset values.
        chk("rst_ce",    ram_ce[0], 0);
        chk("rst_rr",    ram_rr[0], 0);
        chk("rst_addr",  ram_address[0], 0);
        chk("rst_data",  ram_in_data[0], 0);
        chk("rst_done",  init_done[0], 0);
        chk("rst_rsp",   rsp_valid[0], 0);
        chk("rst_rdata", rsp_rdata[0], 0);
        chk("rst_rdy",   req_ready[0], 0);
        chk("rst1_done", init_done[1], 1);
        chk("rst1_rdy",  req_ready[1], 1);
        chk("rst1_ce",   ram_ce[1], 0);

        // Zero-fill, then every word reads back 0.
        rst = 1'b0;
        init_seq();
        for (int a = 0; a < 8; a++) do_read(0, 3'(a), 16'h0000, 1'b1);

        // Write then read-back.
        do_write(0, 3'd3, 16'h5A5A, 1'b1);
        do_read(0, 3'd3, 16'h5A5A, 1'b1);

        // Back-to-back writes with req_valid held high: accepts two cycles apart.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 3'd0; req_wdata[0] = 16'h1111;
        step();
        chk("b2b_ce0",   ram_ce[0], 1);
        chk("b2b_addr0", ram_address[0], 0);
        chk("b2b_data0", ram_in_data[0], 16'h1111);
        chk("b2b_busy",  req_ready[0], 0);
        req_addr[0] = 3'd1; req_wdata[0] = 16'h2222;
        step();
        chk("b2b_gap_ce",  ram_ce[0], 0);
        chk("b2b_gap_rdy", req_ready[0], 1);
        step();
        chk("b2b_ce1",   ram_ce[0], 1);
        chk("b2b_rr1",   ram_rr[0], 1);
        chk("b2b_addr1", ram_address[0], 1);
        chk("b2b_data1", ram_in_data[0], 16'h2222);
        req_valid[0] = 1'b0;
        step();
        chk("b2b_end_ce", ram_ce[0], 0);
        do_read(0, 3'd0, 16'h1111, 1'b1);
        do_read(0, 3'd1, 16'h2222, 1'b1);

        // Response back-pressure: held for 5 cycles, pending write not accepted.
        do_write(0, 3'd7, 16'hBEEF, 1'b1);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 3'd7;
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        chk("bp_valid", rsp_valid[0], 1);
        chk("bp_data",  rsp_rdata[0], 16'hBEEF);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 3'd0; req_wdata[0] = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp_hold_valid%0d", k), rsp_valid[0], 1);
            chk($sformatf("bp_hold_data%0d", k),  rsp_rdata[0], 16'hBEEF);
            chk($sformatf("bp_hold_rdy%0d", k),   req_ready[0], 0);
            chk($sformatf("bp_hold_ce%0d", k),    ram_ce[0], 0);
        end
        rsp_ready[0] = 1'b1;
        step();
        chk("bp_clr",    rsp_valid[0], 0);
        chk("bp_rdy",    req_ready[0], 1);
        chk("bp_clr_ce", ram_ce[0], 0);
        rsp_ready[0] = 1'b0;
        step();
        chk("bp_wr_ce",   ram_ce[0], 1);
        chk("bp_wr_addr", ram_address[0], 0);
        chk("bp_wr_data", ram_in_data[0], 16'hFFFF);
        req_valid[0] = 1'b0;
        step();
        do_read(0, 3'd0, 16'hFFFF, 1'b1);

        // Reset during RD2 discards the read and restarts zero-fill.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 3'd1;
        step();
        req_valid[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rrd2_ce",    ram_ce[0], 0);
        chk("rrd2_rr",    ram_rr[0], 0);
        chk("rrd2_addr",  ram_address[0], 0);
        chk("rrd2_data",  ram_in_data[0], 0);
        chk("rrd2_rsp",   rsp_valid[0], 0);
        chk("rrd2_rdata", rsp_rdata[0], 0);
        chk("rrd2_done",  init_done[0], 0);
        chk("rrd2_rdy",   req_ready[0], 0);
        rst = 1'b0;
        init_seq();
        do_read(0, 3'd1, 16'h0000, 1'b1);

        // INIT_EN=0, 6 words: out-of-range read and write.
        chk("u1_done", init_done[1], 1);
        do_write(1, 3'd5, 16'h1234, 1'b1);
        do_read(1, 3'd5, 16'h1234, 1'b1);
        do_read(1, 3'd6, 16'h0000, 1'b0);
        do_write(1, 3'd7, 16'h9999, 1'b0);
        do_read(1, 3'd5, 16'h1234, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
Request/response front-end that sits directly upstream of the single-port synchronous RAM. It converts a valid/ready request stream into the RAM's ce/rr/address/in_data strobes and returns read data through a one-entry response register. After reset it zero-fills every RAM location before accepting requests. Every RAM-side output is registered.

Parameters:
mem_width, 16, data word width (matches RAM)
mem_length, 8, number of RAM words
add_length, 3, address width (matches RAM)
INIT_EN, 1, 1 = zero-fill RAM after reset; 0 = skip straight to IDLE

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  add_length  request address
req_wdata  in  mem_width  write data
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer takes response
rsp_rdata  out  mem_width  read data
init_done  out  1  zero-fill complete
ram_address  out  add_length  to RAM address
ram_in_data  out  mem_width  to RAM in_data
ram_rr  out  1  to RAM rr (1 = write, 0 = read)
ram_ce  out  1  to RAM ce
ram_out_data  in  mem_width  from RAM out_data (registered in RAM, 1-cycle latency)

Behaviour:
- Reset (rst=1 at an edge): state = INIT (IDLE if INIT_EN=0). cnt=0. rsp_valid=0, rsp_rdata=0, init_done=0 (1 if INIT_EN=0), ram_ce=0, ram_rr=0, ram_address=0, ram_in_data=0. rst overrides everything. A pending response or an in-flight access is discarded.
- States: INIT, IDLE, WR, RD1, RD2.
- INIT: each edge registers ram_ce=1, ram_rr=1, ram_in_data=0, ram_address=cnt, and increments cnt. The edge that emits address mem_length-1 moves to IDLE. The following edge registers ram_ce=0 and init_done=1. init_done then stays 1 until rst. Total of mem_length write strobes, addresses 0..mem_length-1 in order.
- req_ready = (state==IDLE) && !rsp_valid, decoded from registers only. It is never combinationally dependent on req_valid.
- Handshake = req_valid && req_ready at an edge.
- Write accepted at edge A, address in range:
  - Edge A registers ram_ce=1, ram_rr=1, ram_address=req_addr, ram_in_data=req_wdata; state=WR.
  - Edge A+1: RAM commits; ram_ce=0; state=IDLE.
  - No response is generated for writes.
  - Throughput is one write per 2 cycles.
- Read accepted at edge A, address in range:
  - Edge A registers ram_ce=1, ram_rr=0, ram_address=req_addr; state=RD1.
  - Edge A+1: RAM registers out_data. RAM outputs are held unchanged; state=RD2.
  - Edge A+2: rsp_rdata<=ram_out_data, rsp_valid<=1, ram_ce=0, state=IDLE.
  - The strobe is deliberately held through RD2 so that ram_out_data is stable when it is sampled.
- Out-of-range address (req_addr >= mem_length):
  - The request is accepted and no RAM strobe is issued.
  - A write is dropped; state returns to IDLE after one cycle.
  - A read sets rsp_valid=1 with rsp_rdata=0 after the same 2-cycle latency.
- Response register: rsp_valid is cleared at an edge where rsp_ready=1. rsp_rdata holds its value while rsp_valid=1 and rsp_ready=0. No new request is accepted while rsp_valid=1.
- Read-after-write to the same address returns the new data. The write commits at A+1, and the earliest read issue is at A+2.
- ram_rr=0 whenever ram_ce=0. ram_in_data is don't-care during reads but is held at its last value (no X).
- Requests presented during INIT are not accepted (req_ready=0) and must be held by the source.

Test Plan:
- Reset then idle, INIT_EN=1, defaults → ram_ce high exactly 8 cycles with ram_rr=1, addresses 0..7, data 0. init_done rises on the next edge. req_ready=0 throughout INIT. A subsequent read of every address returns 0x0000.
- Write 0x5A5A to addr 3, then read addr 3 → write strobe is 1 cycle with ram_rr=1. rsp_valid rises 2 edges after read acceptance with rsp_rdata=0x5A5A.
- Read addr 7 with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable and req_ready=0 throughout. Raising rsp_ready clears rsp_valid at the next edge, and req_ready=1 the following cycle.
- Back-to-back writes 0x1111→addr0 and 0x2222→addr1, then reads of both → accepts spaced exactly 2 cycles apart. Returned data 0x1111 then 0x2222.
- Reset asserted during RD2 → all outputs at reset values on the next edge, no rsp_valid pulse, and INIT restarts from address 0.
- INIT_EN=0 with mem_length=6: read addr 6 → no ram_ce pulse, rsp_valid after 2 edges with rsp_rdata=0x0000. Write to addr 7 → no ram_ce pulse, and the next read of addr 5 is unaffected.
